// File: rtl/dcache_data_array.sv
`default_nettype none
// ============================================================================
// Module  : dcache_data_array
// Brief   : N-way L1 dcache data store. One byte-strobed line write port
//           (one-hot way select) and one line read port that returns every
//           way at once through a stall/flush-aware output register.
//           After reset, a sweep writes zero to every set of every way.
//           While the sweep runs, external writes are dropped and the read
//           output is held at zero.
// Options : DCACHE_DATA_BYPASS_EN - when defined, a read that captures in
//           the same cycle as a write to the same index sees the newly
//           written bytes (write-first). Otherwise the read returns the
//           pre-write contents (read-first).
// Ports   : clk, rst         - clock, synchronous active-high reset
//           flush, stall     - pipeline flush and stall vector
//           rd_addr_i/rd_en_i             - read request
//           wr_addr_i/wr_way_i/wr_strb_i/wr_data_i - line write request
//           rd_data_o/rd_valid_o          - registered read result
//           init_busy_o      - clear sweep in progress
// Rev     : 1.0 - initial release
// ============================================================================
module dcache_data_array #(
   parameter int WAYS       = 2,
   parameter int SETS       = 256,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_W     = 32,
   parameter int STALL_HOLD = 3,
   parameter int STALL_NEXT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [5:0]                   stall,
   input  logic [ADDR_W-1:0]            rd_addr_i,
   input  logic                         rd_en_i,
   input  logic [ADDR_W-1:0]            wr_addr_i,
   input  logic [WAYS-1:0]              wr_way_i,
   input  logic [LINE_BYTES-1:0]        wr_strb_i,
   input  logic [8*LINE_BYTES-1:0]      wr_data_i,
   output logic [WAYS*8*LINE_BYTES-1:0] rd_data_o,
   output logic                         rd_valid_o,
   output logic                         init_busy_o
);

   localparam int INDEX_W  = $clog2(SETS);
   localparam int OFFSET_W = $clog2(LINE_BYTES);
   localparam int LINE_W   = 8 * LINE_BYTES;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                     r_state;
   logic [INDEX_W-1:0]         r_cnt;
   logic [WAYS*LINE_W-1:0]     r_rd_data;
   logic                       r_rd_valid;

   logic [INDEX_W-1:0]         w_rd_idx;
   logic [INDEX_W-1:0]         w_wr_idx;
   logic                       w_ready;
   logic [WAYS*LINE_W-1:0]     w_rd_next;
   logic                       w_unused;

   // Tag bits above the index are intentionally ignored, so the index wraps
   // modulo SETS.
   assign w_rd_idx = rd_addr_i[OFFSET_W +: INDEX_W];
   assign w_wr_idx = wr_addr_i[OFFSET_W +: INDEX_W];
   assign w_ready  = (r_state == ST_READY);

   // Offset/tag address bits and the other stall bits are not needed here.
   assign w_unused = ^{rd_addr_i, wr_addr_i, stall};

   // Sweep sequencer: one set per cycle, SETS cycles in total.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else if (r_state == ST_INIT) begin
         r_cnt <= r_cnt + INDEX_W'(1);
         if (r_cnt == INDEX_W'(SETS - 1)) begin
            r_state <= ST_READY;
         end
      end
   end

   assign init_busy_o = (r_state == ST_INIT);

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [LINE_W-1:0] r_mem [SETS];
      logic [LINE_W-1:0] w_line;

      always_ff @(posedge clk) begin
         if (!w_ready) begin
            r_mem[r_cnt] <= '0;
         end else if (wr_way_i[w]) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
               if (wr_strb_i[k]) begin
                  r_mem[w_wr_idx][k*8 +: 8] <= wr_data_i[k*8 +: 8];
               end
            end
         end
      end

      always_comb begin
         w_line = r_mem[w_rd_idx];
`ifdef DCACHE_DATA_BYPASS_EN
         // Forward the strobed bytes of a same-index write into the capture.
         if (w_ready && wr_way_i[w] && (w_wr_idx == w_rd_idx)) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
               if (wr_strb_i[k]) begin
                  w_line[k*8 +: 8] = wr_data_i[k*8 +: 8];
               end
            end
         end
`endif
      end

      assign w_rd_next[w*LINE_W +: LINE_W] = w_line;
   end

   // Output register. Hold-stage stall with the next stage running inserts a
   // bubble; both stalled keeps the current result in place.
   always_ff @(posedge clk) begin
      if (rst || flush || !w_ready) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (stall[STALL_HOLD] && !stall[STALL_NEXT]) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (!stall[STALL_HOLD]) begin
         r_rd_data  <= w_rd_next;
         r_rd_valid <= rd_en_i;
      end
   end

   assign rd_data_o  = r_rd_data;
   assign rd_valid_o = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_dcache_data_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_data_array
// Brief   : Directed self-checking bench for dcache_data_array (default
//           parameters: 2 ways, 256 sets, 64-byte lines).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_dcache_data_array;

   localparam int LW = 512;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [5:0]      stall = '0;
   logic [31:0]     rd_addr = '0;
   logic            rd_en = 1'b0;
   logic [31:0]     wr_addr = '0;
   logic [1:0]      wr_way = '0;
   logic [63:0]     wr_strb = '0;
   logic [LW-1:0]   wr_data = '0;
   logic [2*LW-1:0] rd_data;
   logic            rd_valid;
   logic            init_busy;

   int n_chk = 0;
   int n_bad = 0;

   dcache_data_array dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .stall      (stall),
      .rd_addr_i  (rd_addr),
      .rd_en_i    (rd_en),
      .wr_addr_i  (wr_addr),
      .wr_way_i   (wr_way),
      .wr_strb_i  (wr_strb),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .init_busy_o(init_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      assert ($onehot0(wr_way)) else $error("multi-way write select");
   end

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] way, input logic [31:0] addr,
                     input logic [63:0] strb, input logic [LW-1:0] data);
      wr_way  = way;
      wr_addr = addr;
      wr_strb = strb;
      wr_data = data;
      tick;
      wr_way  = '0;
   endtask

   task automatic rd(input logic [31:0] addr);
      rd_addr = addr;
      rd_en   = 1'b1;
      tick;
   endtask

   // Counts busy cycles, tries a write to index 3 at sweep cycle 50 (already
   // cleared by then, so a leaked write would survive) and checks the array
   // reads zero afterwards.
   task automatic sweep(input string tag);
      int   n = 0;
      logic seen = 1'b0;
      rd_en   = 1'b1;
      rd_addr = '0;
      while (init_busy && n < 400) begin
         if (n == 50) begin
            wr_way  = 2'b01;
            wr_addr = 32'h3 << 6;
            wr_strb = '1;
            wr_data = {64{8'h5A}};
         end else begin
            wr_way = '0;
         end
         tick;
         n++;
         if (rd_valid || (rd_data != '0)) seen = 1'b1;
      end
      wr_way = '0;
      chk({tag, "_busy_len"}, LW'(n), LW'(256));
      chk({tag, "_rd_blocked"}, LW'(seen), LW'(0));
      rd(32'hFF << 6);
      chk({tag, "_ff_way0"}, rd_data[LW-1:0], '0);
      chk({tag, "_ff_way1"}, rd_data[2*LW-1:LW], '0);
      chk({tag, "_ff_valid"}, LW'(rd_valid), LW'(1));
      rd(32'h3 << 6);
      chk({tag, "_drop_wr"}, rd_data[LW-1:0], '0);
   endtask

   logic [LW-1:0] exp_line;

   initial begin
      // Reset state
      tick;
      chk("rst_valid", LW'(rd_valid), LW'(0));
      chk("rst_data", rd_data[LW-1:0], '0);
      chk("rst_busy", LW'(init_busy), LW'(1));
      rst = 1'b0;
      sweep("boot");

      // Garbage in set 0xFF, then reset must clear it
      wr(2'b01, 32'hFF << 6, '1, {64{8'hA5}});
      wr(2'b10, 32'hFF << 6, '1, {64{8'hC3}});
      rd(32'hFF << 6);
      chk("garb_way0", rd_data[LW-1:0], {64{8'hA5}});
      chk("garb_way1", rd_data[2*LW-1:LW], {64{8'hC3}});
      rst = 1'b1; tick; rst = 1'b0;
      sweep("clr");

      // Reset mid-sweep restarts it in full
      rst = 1'b1; tick; rst = 1'b0;
      repeat (100) tick;
      chk("mid_busy", LW'(init_busy), LW'(1));
      rst = 1'b1; tick; rst = 1'b0;
      sweep("mid");

      // Partial write, way 1, index 0x12
      wr(2'b10, 32'h0000_0480, 64'hF, LW'(32'hDEAD_BEEF));
      rd(32'h0000_0480);
      chk("part_way1", rd_data[2*LW-1:LW], LW'(32'hDEAD_BEEF));
      chk("part_way0", rd_data[LW-1:0], '0);
      chk("part_valid", LW'(rd_valid), LW'(1));

      // Stall handling
      stall = 6'b001000; tick;
      chk("bubble_data", rd_data[2*LW-1:LW], '0);
      chk("bubble_valid", LW'(rd_valid), LW'(0));
      stall = 6'b000000; tick;
      chk("resume_data", rd_data[2*LW-1:LW], LW'(32'hDEAD_BEEF));
      stall = 6'b011000;
      rd_addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("hold%0d_data", i), rd_data[2*LW-1:LW], LW'(32'hDEAD_BEEF));
         chk($sformatf("hold%0d_valid", i), LW'(rd_valid), LW'(1));
      end
      stall = 6'b000000; tick;
      chk("unstall_new", rd_data[2*LW-1:LW], '0);
      rd(32'h0000_0480);
      chk("reload", rd_data[2*LW-1:LW], LW'(32'hDEAD_BEEF));
      flush = 1'b1; tick; flush = 1'b0;
      chk("flush_data", rd_data[2*LW-1:LW], '0);
      chk("flush_valid", LW'(rd_valid), LW'(0));
      rd_en = 1'b0; tick;
      chk("noen_data", rd_data[2*LW-1:LW], LW'(32'hDEAD_BEEF));
      chk("noen_valid", LW'(rd_valid), LW'(0));

      // Same-cycle read/write at index 5, way 0
      wr(2'b01, 32'h5 << 6, '1, {64{8'h11}});
      rd_addr = 32'h5 << 6;
      rd_en   = 1'b1;
      wr(2'b01, 32'h5 << 6, 64'h1, {{63{8'h33}}, 8'h22});
      exp_line = {64{8'h11}};
`ifdef DCACHE_DATA_BYPASS_EN
      exp_line[7:0] = 8'h22;
`endif
      chk("same_cyc", rd_data[LW-1:0], exp_line);
      tick;
      exp_line = {{63{8'h11}}, 8'h22};
      chk("next_cyc", rd_data[LW-1:0], exp_line);

      // Index wrap: tag bits ignored
      wr(2'b01, 32'h0001_0000, '1, {16{32'hCAFE_F00D}});
      rd(32'h0000_0000);
      chk("wrap_way0", rd_data[LW-1:0], {16{32'hCAFE_F00D}});
      chk("wrap_way1", rd_data[2*LW-1:LW], '0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_data_array.md
Name: dcache_data_array

Overview:
- Parametrised N-way data store for the L1 dcache; successor to the single-way 16-bank line RAM.
- Sits between the dcache controller and the MEM stage.
- One byte-strobed line write port and one line read port returning all ways at once. The output register honours the pipeline stall vector and flush.
- Adds two things the single-way store lacks: a post-reset zero-clear sweep, and optional write-to-read forwarding.

Parameters:
- WAYS, 2, number of ways; read returns all ways, write selects one-hot.
- SETS, 256, sets per way; power of two, at least 2. INDEX_W = log2(SETS).
- LINE_BYTES, 64, bytes per line; power of two, at least 4. OFFSET_W = log2(LINE_BYTES), LINE_W = 8*LINE_BYTES.
- ADDR_W, 32, address width; must satisfy ADDR_W >= OFFSET_W + INDEX_W.
- STALL_HOLD, 3, stall-vector bit of the owning stage (MEM).
- STALL_NEXT, 4, stall-vector bit of the following stage (WB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high; restarts the clear sweep.
- flush  in  1  pipeline flush; zeroes the read output register.
- stall  in  6  pipeline stall vector; bit = 1 means stop.
- rd_addr_i  in  ADDR_W  read address; index = [OFFSET_W+INDEX_W-1:OFFSET_W].
- rd_en_i  in  1  read request.
- wr_addr_i  in  ADDR_W  write address; same index slice as the read address.
- wr_way_i  in  WAYS  one-hot way select; all-zero means no write.
- wr_strb_i  in  LINE_BYTES  byte enables; bit k covers byte k of the line, little-endian.
- wr_data_i  in  LINE_W  write line data.
- rd_data_o  out  WAYS*LINE_W  registered read data; way w at [(w+1)*LINE_W-1 : w*LINE_W].
- rd_valid_o  out  1  registered; rd_data_o holds a real read result.
- init_busy_o  out  1  clear sweep in progress.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: rd_data_o = 0, rd_valid_o = 0, init_busy_o = 1, sweep counter = 0, state = INIT.
- State machine: INIT -> READY.
  - INIT: each cycle, write zero to set cnt in all ways; cnt increments.
  - When cnt == SETS-1 the write still occurs; next state is READY and init_busy_o drops to 0.
  - init_busy_o is high for exactly SETS cycles after rst deasserts.
  - rst asserted in any state returns to INIT with cnt = 0; the sweep restarts in full.
- In INIT:
  - External writes are dropped; no array change other than the sweep.
  - Read output register is forced to rd_data_o = 0, rd_valid_o = 0.
- Write (READY only):
  - At a rising edge, for each way w with wr_way_i[w] = 1 and each byte k with wr_strb_i[k] = 1: array[w][index][k] <= wr_data_i byte k.
  - Unstrobed bytes are unchanged.
  - More than one wr_way_i bit set is illegal; the bench asserts against it and the RTL does not define the result.
- Read output register, evaluated at each rising edge in priority order:
  1. rst or flush: rd_data_o <= 0, rd_valid_o <= 0.
  2. INIT: rd_data_o <= 0, rd_valid_o <= 0.
  3. stall[STALL_HOLD] = 1 and stall[STALL_NEXT] = 0: bubble; rd_data_o <= 0, rd_valid_o <= 0.
  4. stall[STALL_HOLD] = 0: rd_data_o <= all ways of array[rd index]; rd_valid_o <= rd_en_i. If rd_en_i = 0, data is still loaded but rd_valid_o = 0.
  5. Otherwise (both stall bits set): hold rd_data_o and rd_valid_o.
- Latency: address at edge N gives data visible after edge N, i.e. one cycle.
- Tag bits above the index are ignored; index wraps modulo SETS.

Optional Feature:
- Macro: DCACHE_DATA_BYPASS_EN.
- Defined: when case 4 captures, a write in the same cycle with equal index forwards its new bytes. Strobed bytes of the written way come from wr_data_i; all other bytes come from the array. The result is write-first.
- Undefined: the same case returns the pre-write contents (read-first); new data is visible from the next read.
- Either way, array contents after the edge are identical.

Test Plan:
- Clear sweep (SETS = 256): pre-load garbage by backdoor, pulse rst 1 cycle. Expect init_busy_o = 1 for exactly 256 cycles, then 0. A read of index 0xFF afterwards returns all zero with rd_valid_o = 1.
- Reset mid-sweep: rst at sweep cycle 100. Expect init_busy_o stays 1 for a further 256 cycles after deassert. A write issued at cycle 50 post-reset has no effect.
- Partial write: write way 1, index 0x12, strb = 0x0000_0000_0000_000F, data byte0..3 = 0xDEADBEEF. Read 0x0000_0480: way 1 bytes 3..0 = DE AD BE EF, rest 0; way 0 all 0.
- Stall handling:
  - stall = 6'b001000: next edge gives rd_data_o = 0, rd_valid_o = 0.
  - stall = 6'b011000: output holds its prior value for 3 cycles.
  - stall = 0: new data after one edge.
  - flush for 1 cycle zeroes the output.
- Same-cycle read/write: line at index 5 way 0 = all 0x11. Write strb bit 0 with byte 0x22 and read index 5 in the same cycle.
  - With DCACHE_DATA_BYPASS_EN: rd byte0 = 0x22.
  - Without it: 0x11; a read on the next cycle returns 0x22.
- Index wrap: write address 0x0001_0000 (index 0, tag differs), then read 0x0000_0000. Expect the same data.
